// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux_scan_ctrl: serializes a captured 16-bit word by stepping a 16:1 mux select
// Revision: 1.0
// ----------------------------------------------------------------------------
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] data,
  input  logic        dir,
  input  logic [3:0]  len,
  output logic [15:0] w,
  output logic [3:0]  s,
  output logic        valid,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] C_DWELL_LAST = 4'(DWELL - 1);
  localparam logic       C_SINGLE     = (DWELL == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_dwell, w_dwell_next;
  logic [3:0]  r_bit, w_bit_next;
  logic [3:0]  r_len, w_len_next;
  logic        r_dir, w_dir_next;
  logic [15:0] w_w_next;
  logic [3:0]  w_s_next;
  logic        w_valid_next, w_busy_next, w_done_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_dwell <= 4'd0;
      r_bit   <= 4'd0;
      r_len   <= 4'd0;
      r_dir   <= 1'b0;
      w       <= 16'h0000;
      s       <= 4'h0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_dwell <= w_dwell_next;
      r_bit   <= w_bit_next;
      r_len   <= w_len_next;
      r_dir   <= w_dir_next;
      w       <= w_w_next;
      s       <= w_s_next;
      valid   <= w_valid_next;
      busy    <= w_busy_next;
      done    <= w_done_next;
    end
  end

  // Outputs are registered, so every *_next value describes the following cycle.
  always_comb begin
    w_state_next = r_state;
    w_dwell_next = r_dwell;
    w_bit_next   = r_bit;
    w_len_next   = r_len;
    w_dir_next   = r_dir;
    w_w_next     = w;
    w_s_next     = s;
    w_valid_next = 1'b0;
    w_busy_next  = 1'b0;
    w_done_next  = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = SCAN;
          w_w_next     = data;
          w_s_next     = dir ? 4'hF : 4'h0;
          w_dir_next   = dir;
          w_len_next   = len;
          w_dwell_next = 4'd0;
          w_bit_next   = 4'd0;
          w_busy_next  = 1'b1;
          w_valid_next = C_SINGLE;
        end
      end
      SCAN: begin
        w_busy_next = 1'b1;
        if (r_dwell == C_DWELL_LAST) begin
          if (r_bit == r_len) begin
            w_state_next = DONE;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
          end else begin
            w_s_next     = r_dir ? (s - 4'd1) : (s + 4'd1);
            w_bit_next   = r_bit + 4'd1;
            w_dwell_next = 4'd0;
            w_valid_next = C_SINGLE;
          end
        end else begin
          w_dwell_next = r_dwell + 4'd1;
          w_valid_next = ((r_dwell + 4'd1) == C_DWELL_LAST);
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mux_scan_ctrl: scoreboard bench driving DWELL=1 and DWELL=3 instances in lockstep
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

  localparam int MAXC = 4096;

  typedef struct {
    int          cyc;
    logic [3:0]  s;
    logic        f;
    logic [15:0] w;
  } exp_t;

  logic        clk;
  logic        rst, start, dir;
  logic [15:0] data;
  logic [3:0]  len;

  logic [15:0] w_o     [2];
  logic [3:0]  s_o     [2];
  logic        valid_o [2];
  logic        busy_o  [2];
  logic        done_o  [2];

  exp_t        vq [2][$];
  int          dq [2][$];
  bit          exp_busy [2][MAXC];
  logic [15:0] exp_hw   [2][MAXC];
  logic [3:0]  exp_hs   [2][MAXC];
  int          free_at  [2];
  int          scan_end [2];
  logic [15:0] hold_w   [2];
  logic [3:0]  hold_s   [2];

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;
  bit stim_done = 0;

  mux_scan_ctrl #(.DWELL(1)) u_dut1 (
    .clock(clk), .reset(rst), .start(start), .data(data), .dir(dir), .len(len),
    .w(w_o[0]), .s(s_o[0]), .valid(valid_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  mux_scan_ctrl #(.DWELL(3)) u_dut3 (
    .clock(clk), .reset(rst), .start(start), .data(data), .dir(dir), .len(len),
    .w(w_o[1]), .s(s_o[1]), .valid(valid_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a scan is an interval of (Len+1)*DWELL cycles whose sample
  // points and done cycle follow directly from arithmetic on the start edge.
  task automatic model_edge(input int n);
    exp_t e;
    int   d;
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? 1 : 3;
      if (rst) begin
        vq[i].delete();
        dq[i].delete();
        free_at[i]  = n + 1;
        scan_end[i] = n;
        hold_w[i]   = 16'h0000;
        hold_s[i]   = 4'h0;
      end else if (start && n >= free_at[i]) begin
        for (int k = 0; k <= int'(len); k++) begin
          e.cyc = n + k * d + d - 1;
          e.s   = dir ? 4'(15 - k) : 4'(k);
          e.w   = data;
          e.f   = data[e.s];
          vq[i].push_back(e);
        end
        scan_end[i] = n + (int'(len) + 1) * d;
        dq[i].push_back(scan_end[i]);
        free_at[i] = scan_end[i] + 2;
        hold_w[i]  = data;
        hold_s[i]  = dir ? 4'(15 - int'(len)) : len;
      end
      if (n < MAXC) begin
        exp_busy[i][n] = (n < scan_end[i]);
        exp_hw[i][n]   = hold_w[i];
        exp_hs[i][n]   = hold_s[i];
      end
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic [15:0] dv,
                       input logic di, input logic [3:0] l);
    @(negedge clk);
    #1;
    rst = r; start = st; data = dv; dir = di; len = l;
    model_edge(cyc + 1);
    @(posedge clk);
    cyc = cyc + 1;
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++)
      drive(1'b0, 1'b0, 16'($urandom), 1'($urandom), 4'($urandom));
  endtask

  // Stimulus
  initial begin
    logic [15:0] rd;
    rst = 1'b1; start = 1'b0; data = 16'h0; dir = 1'b0; len = 4'h0;
    for (int i = 0; i < 2; i++) begin
      free_at[i] = 0; scan_end[i] = 0; hold_w[i] = 16'h0; hold_s[i] = 4'h0;
    end
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    drive(1'b1, 1'b1, 16'h1234, 1'b1, 4'h7);
    drive(1'b0, 1'b1, 16'hA5C3, 1'b0, 4'hF);
    idle(55);
    drive(1'b0, 1'b1, 16'h8001, 1'b1, 4'h3);
    idle(16);
    drive(1'b0, 1'b1, 16'($urandom), 1'b0, 4'h1);
    idle(10);
    for (int k = 0; k < 15; k++) drive(1'b0, 1'b1, 16'($urandom), 1'b0, 4'h0);
    idle(8);
    drive(1'b0, 1'b1, 16'hBEEF, 1'($urandom), 4'hF);
    idle(4);
    drive(1'b1, 1'b0, 16'($urandom), 1'b0, 4'h0);
    drive(1'b0, 1'b1, 16'h0F0F, 1'b1, 4'h5);
    idle(25);
    for (int k = 0; k < 2000; k++) begin
      rd = 16'($urandom);
      drive(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 2) == 0),
            rd, 1'($urandom), 4'($urandom));
    end
    idle(60);
    stim_done = 1'b1;
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (stim_done) begin
        for (int i = 0; i < 2; i++) begin
          n_tests++;
          if (vq[i].size() != 0 || dq[i].size() != 0) begin
            n_fail++;
            $display("FAIL leftover[%0d]: got %0d samples %0d dones pending, want 0 0",
                     i, vq[i].size(), dq[i].size());
          end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
      if (cyc >= 1 && cyc < MAXC) begin
        for (int i = 0; i < 2; i++) begin
          n_tests++;
          if (busy_o[i] !== exp_busy[i][cyc]) begin
            n_fail++;
            $display("FAIL busy[%0d] cyc %0d: got %b want %b", i, cyc, busy_o[i], exp_busy[i][cyc]);
          end
          if (!exp_busy[i][cyc]) begin
            n_tests++;
            if (w_o[i] !== exp_hw[i][cyc] || s_o[i] !== exp_hs[i][cyc]) begin
              n_fail++;
              $display("FAIL hold[%0d] cyc %0d: got w=%h s=%h want w=%h s=%h",
                       i, cyc, w_o[i], s_o[i], exp_hw[i][cyc], exp_hs[i][cyc]);
            end
          end
          if (vq[i].size() != 0 && vq[i][0].cyc == cyc) begin
            e = vq[i].pop_front();
            n_tests++;
            if (valid_o[i] !== 1'b1 || s_o[i] !== e.s || w_o[i] !== e.w || w_o[i][s_o[i]] !== e.f) begin
              n_fail++;
              $display("FAIL sample[%0d] cyc %0d: got v=%b s=%h w=%h f=%b want v=1 s=%h w=%h f=%b",
                       i, cyc, valid_o[i], s_o[i], w_o[i], w_o[i][s_o[i]], e.s, e.w, e.f);
            end
          end else if (valid_o[i] !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL valid[%0d] cyc %0d: got %b want 0", i, cyc, valid_o[i]);
          end
          if (dq[i].size() != 0 && dq[i][0] == cyc) begin
            void'(dq[i].pop_front());
            n_tests++;
            if (done_o[i] !== 1'b1) begin
              n_fail++;
              $display("FAIL done[%0d] cyc %0d: got %b want 1", i, cyc, done_o[i]);
            end
          end else if (done_o[i] !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done[%0d] cyc %0d: got %b want 0", i, cyc, done_o[i]);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
